window_buffer: RTL and testbench

WINDOW_BUFFER -- requirements
Module: window_buffer

---
 rtl/window_buffer_pkg.sv | 19 +
 rtl/window_buffer_line_buffer.sv | 22 ++
 rtl/window_buffer.sv | 133 +++++++++++++
 tb/tb_window_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/window_buffer_pkg.sv
// Shared constants for the 3x3 window buffer and the sum-of-products stage that consumes it.
// Optional window counter is enabled by defining WINDOW_BUFFER_WINCNT_EN.
package window_buffer_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int WIN_PIX   = 9;

  // Window taps in row-major order: P0 is top-left, P8 is bottom-right.
  typedef enum logic [3:0] {
    P0 = 4'd0, P1 = 4'd1, P2 = 4'd2,
    P3 = 4'd3, P4 = 4'd4, P5 = 4'd5,
    P6 = 4'd6, P7 = 4'd7, P8 = 4'd8
  } win_tap_e;

  function automatic int tap_lsb(input win_tap_e tap, input int pix_w);
    return int'(tap) * pix_w;
  endfunction

endpackage

// File: rtl/window_buffer_line_buffer.sv
// One image row of pixel storage; read data is the value stored before this cycle's write.
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_buffer.sv
// Raster-order pixel stream to interior 3x3 windows, using two line buffers and a shift window.
// Define WINDOW_BUFFER_WINCNT_EN to add the saturating win_count output.
module window_buffer
  import window_buffer_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_pixel,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIN_PIX*PIX_W-1:0]   out_win,
  output logic                       out_last
`ifdef WINDOW_BUFFER_WINCNT_EN
  ,
  output logic [15:0]                win_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_out_valid;
  logic             r_out_last;
  logic [PIX_W-1:0] r_win [WIN_PIX];

  logic             w_accept;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_win_en;
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) regardless of the running position.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_col_last = (w_col == CW'(IMG_W - 1));
  assign w_row_last = (w_row == RW'(IMG_H - 1));
  assign w_win_en   = (w_row >= RW'(2)) && (w_col >= CW'(2));

  // lb0 holds the previous row; lb1 receives what lb0 held, i.e. two rows back.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (in_pixel),
    .o_rdata (w_lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      r_col <= w_col_last ? '0 : w_col + CW'(1);
      if (w_col_last) r_row <= w_row_last ? '0 : w_row + RW'(1);
      else            r_row <= w_row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_PIX; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]   <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
      end
      r_win[int'(P2)] <= w_lb1_rd;
      r_win[int'(P5)] <= w_lb0_rd;
      r_win[int'(P8)] <= in_pixel;
    end
  end

  // Stalls cannot disturb the window: nothing is accepted while out_valid waits on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= w_win_en;
      r_out_last  <= w_win_en && w_col_last && w_row_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  for (genvar g = 0; g < WIN_PIX; g++) begin : g_out
    assign out_win[tap_lsb(win_tap_e'(g), PIX_W) +: PIX_W] = r_win[g];
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

`ifdef WINDOW_BUFFER_WINCNT_EN
  logic [15:0] r_win_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_count <= '0;
    end else if (w_accept && in_sof) begin
      r_win_count <= '0;
    end else if (r_out_valid && out_ready && (r_win_count != 16'hFFFF)) begin
      r_win_count <= r_win_count + 16'd1;
    end
  end

  assign win_count = r_win_count;
`endif

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer on a 4x4 frame; win_count checks run when WINDOW_BUFFER_WINCNT_EN is defined.
module tb_window_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          out_ready = 1'b1;
  logic [PW-1:0] in_pixel = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic [71:0]   out_win;
`ifdef WINDOW_BUFFER_WINCNT_EN
  logic [15:0]   win_count;
`endif

  always #5 clk = ~clk;

  window_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
    .out_last  (out_last)
`ifdef WINDOW_BUFFER_WINCNT_EN
    ,
    .win_count (win_count)
`endif
  );

  typedef struct {
    int p[9];
    bit last;
  } vec_t;

  typedef struct {
    logic [71:0] win;
    logic        last;
  } win_t;

  vec_t vecs[4];
  win_t gotQ[$];
  int   checks = 0;
  int   errors = 0;

  // Record every window handshake seen by the downstream stage.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) gotQ.push_back('{out_win, out_last});
  end

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] expWin(input int k, input int base);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(base + vecs[k].p[i]);
    return w;
  endfunction

  task automatic applyStimulus(input int pix, input bit sof);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_pixel = 8'(pix);
    in_sof   = sof;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: pixel %0d not accepted within 50 cycles", pix);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic sendFrame(input int base);
    for (int i = 0; i < W*H; i++) applyStimulus(base + i, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkWindows(input string name, input int nFrames, input int base0, input int base1);
    int idx;
    checkOutput($sformatf("%s_count", name), 72'(gotQ.size()), 72'(4 * nFrames));
    for (int f = 0; f < nFrames; f++) begin
      for (int k = 0; k < 4; k++) begin
        idx = f*4 + k;
        if (idx < gotQ.size()) begin
          checkOutput($sformatf("%s_win%0d", name, idx), gotQ[idx].win, expWin(k, (f == 0) ? base0 : base1));
          checkOutput($sformatf("%s_last%0d", name, idx), 72'(gotQ[idx].last), 72'(vecs[k].last));
        end
      end
    end
    gotQ.delete();
  endtask

  initial begin
    vecs[0] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},   1'b0};
    vecs[1] = '{'{1, 2, 3, 5, 6, 7, 9, 10, 11},  1'b0};
    vecs[2] = '{'{4, 5, 6, 8, 9, 10, 12, 13, 14}, 1'b0};
    vecs[3] = '{'{5, 6, 7, 9, 10, 11, 13, 14, 15}, 1'b1};

    #12;
    checkOutput("reset_out_valid", 72'(out_valid), 72'(0));
    checkOutput("reset_out_last",  72'(out_last),  72'(0));
    checkOutput("reset_out_win",   out_win,        72'(0));
    checkOutput("reset_in_ready",  72'(in_ready),  72'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] case 1: single frame, free-running output");
    sendFrame(0);
    idle(2);
    checkWindows("case1", 1, 0, 0);
`ifdef WINDOW_BUFFER_WINCNT_EN
    checkOutput("wincnt_after_frame", 72'(win_count), 72'(4));
`endif

    $display("[TB] case 2: three-cycle stall at the first window");
    applyStimulus(0, 1'b1);
`ifdef WINDOW_BUFFER_WINCNT_EN
    checkOutput("wincnt_sof_clear", 72'(win_count), 72'(0));
`endif
    for (int i = 1; i <= 10; i++) applyStimulus(i, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pixel  = 8'd11;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_in_ready", c), 72'(in_ready), 72'(0));
      checkOutput($sformatf("stall%0d_out_valid", c), 72'(out_valid), 72'(1));
      checkOutput($sformatf("stall%0d_out_win", c), out_win, expWin(0, 0));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 11; i < 16; i++) applyStimulus(i, 1'b0);
    idle(2);
    checkWindows("case2", 1, 0, 0);

    $display("[TB] case 3: start-of-frame restarts a partial frame");
    for (int i = 0; i < 7; i++) applyStimulus(i, 1'b0);
    applyStimulus(100, 1'b1);
    for (int i = 1; i < 16; i++) applyStimulus(100 + i, 1'b0);
    idle(2);
    checkWindows("case3", 1, 100, 0);

    $display("[TB] case 4: asynchronous reset mid-frame");
    for (int i = 0; i < 11; i++) applyStimulus(i, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_out_valid", 72'(out_valid), 72'(0));
    checkOutput("arst_out_last",  72'(out_last),  72'(0));
    checkOutput("arst_out_win",   out_win,        72'(0));
    checkOutput("arst_in_ready",  72'(in_ready),  72'(1));
    gotQ.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sendFrame(0);
    idle(2);
    checkWindows("case4", 1, 0, 0);

    $display("[TB] case 5: two back-to-back frames without start-of-frame");
    sendFrame(0);
    sendFrame(50);
    idle(2);
    checkWindows("case5", 2, 0, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
